// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg: shared divider width and type for the clock divider slice
package clock_divider_pkg;
   localparam int DIV_WIDTH = 32;
   typedef logic [DIV_WIDTH-1:0] div_t;
endpackage

// File: rtl/clock_divider_counter.sv
// clock_divider_counter: half-period counter with a shadow divider register
//   clk_in   - input clock, rising edge
//   reset    - asynchronous active-low reset
//   divider  - requested half-period length (0 = disabled)
//   boundary - high during the last cycle of a half-period
//   next_div - divider value that the coming boundary edge will sample
module clock_divider_counter
   import clock_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic [WIDTH-1:0] divider,
   output logic             boundary,
   output logic [WIDTH-1:0] next_div
);
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] active_div;
   // active_div-1 is only meaningful while running, so the compare is gated on it
   assign boundary = (active_div != '0) && (count == active_div - 1'b1);
   assign next_div = divider;
   always_ff @(posedge clk_in or negedge reset)
      if (!reset) begin
         count      <= '0;
         active_div <= '0;
      end else if (active_div == '0)
         active_div <= divider;
      else if (boundary) begin
         count      <= '0;
         active_div <= divider;
      end else
         count <= count + 1'b1;
endmodule

// File: rtl/clock_divider.sv
// clock_divider: glitch-free 50%-duty programmable clock divider
//   clk_in  - input clock, rising edge
//   reset   - asynchronous active-low reset
//   divider - half-period length in clk_in cycles (0 = output disabled)
//   clk_out - divided clock, driven straight from a flop
module clock_divider
   import clock_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic [WIDTH-1:0] divider,
   output logic             clk_out
);
   logic             boundary;
   logic [WIDTH-1:0] next_div;
   clock_divider_counter #(.WIDTH(WIDTH)) u_counter (
      .clk_in   (clk_in),
      .reset    (reset),
      .divider  (divider),
      .boundary (boundary),
      .next_div (next_div)
   );
   // clk_out only moves on a boundary; a zero divider sampled there parks it low
   always_ff @(posedge clk_in or negedge reset)
      if (!reset)
         clk_out <= 1'b0;
      else if (boundary)
         clk_out <= (next_div != '0) & ~clk_out;
endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: randomized scoreboard bench for clock_divider
module tb_clock_divider;
   import clock_divider_pkg::*;
   logic  clk_in = 1'b0;
   logic  reset = 1'b0;
   div_t  divider = '0;
   logic  clk_out;
   int    n_tests = 0;
   int    n_fail = 0;
   string phase = "reset";
   bit    exp_q[$];
   bit    m_idle = 1'b1;
   bit    m_level = 1'b0;
   longint m_t = 0;
   longint m_toggle = 0;

   clock_divider dut (
      .clk_in  (clk_in),
      .reset   (reset),
      .divider (divider),
      .clk_out (clk_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: clk_out=%b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks the absolute edge number at which the next toggle is due
   always @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         m_idle  = 1'b1;
         m_level = 1'b0;
      end else begin
         m_t++;
         if (m_idle) begin
            if (divider != '0) begin
               m_idle   = 1'b0;
               m_toggle = m_t + longint'(divider);
            end
         end else if (m_t == m_toggle) begin
            if (divider == '0) begin
               m_idle  = 1'b1;
               m_level = 1'b0;
            end else begin
               m_level  = !m_level;
               m_toggle = m_t + longint'(divider);
            end
         end
         exp_q.push_back(m_level);
      end
   end

   // Monitor: compares clk_out one time unit after every rising edge
   always @(posedge clk_in) begin
      #1;
      if (!reset)
         check({phase, "_in_reset"}, clk_out, 1'b0);
      else if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_queue: no expected value queued at %0t", phase, $time);
      end else
         check(phase, clk_out, exp_q.pop_front());
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic wait_level(input logic lvl);
      for (int i = 0; i < 200 && clk_out !== lvl; i++) @(negedge clk_in);
      if (clk_out !== lvl) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_wait: clk_out=%b never reached %b", phase, clk_out, lvl);
      end
   endtask

   initial begin
      divider = 7;
      cycles(50);
      phase = "idle";
      divider = 0;
      reset = 1'b1;
      cycles(60);
      phase = "div4";
      divider = 4;
      cycles(8 * 1000 + 8);
      phase = "div1";
      divider = 1;
      cycles(40);
      phase = "div2";
      divider = 2;
      cycles(40);
      phase = "change";
      divider = 4;
      wait_level(1'b0);
      wait_level(1'b1);
      cycles(2);
      divider = 2;
      cycles(20);
      wait_level(1'b1);
      cycles(1);
      divider = 6;
      cycles(40);
      phase = "disable";
      divider = 3;
      cycles(30);
      wait_level(1'b1);
      cycles(1);
      divider = 0;
      cycles(30);
      phase = "restart";
      divider = 3;
      cycles(30);
      phase = "async";
      wait_level(1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_immediate", clk_out, 1'b0);
      cycles(5);
      reset = 1'b1;
      cycles(40);
      phase = "random";
      repeat (400) begin
         divider = ($urandom_range(0, 4) == 0) ? div_t'(0) : div_t'($urandom_range(1, 9));
         cycles($urandom_range(1, 25));
      end
      cycles(3);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
